// File: rtl/rle_stream_arb_if.sv
// Bundle of source, encoder and sink handshakes around the shared RLE encoder.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface rle_stream_arb_if #(
  parameter int unsigned CNT_W = 16
);
  logic             src0_recv_ready;
  logic [7:0]       src0_data;
  logic             src0_eos;
  logic             src0_rd_req;
  logic             src1_recv_ready;
  logic [7:0]       src1_data;
  logic             src1_eos;
  logic             src1_rd_req;
  logic             enc_recv_ready;
  logic [7:0]       enc_in_data;
  logic             enc_end_of_stream;
  logic             enc_rd_req;
  logic             enc_send_ready;
  logic [23:0]      enc_out_data;
  logic             enc_wr_req;
  logic             dst0_send_ready;
  logic             dst1_send_ready;
  logic             dst0_wr_req;
  logic             dst1_wr_req;
  logic [23:0]      dst_data;
  logic             owner;
  logic             busy;
  logic             drain_timeout;
  logic [CNT_W-1:0] stream_cnt0;
  logic [CNT_W-1:0] stream_cnt1;

  modport slave (
    input  src0_recv_ready, src0_data, src0_eos,
    input  src1_recv_ready, src1_data, src1_eos,
    input  enc_rd_req, enc_out_data, enc_wr_req,
    input  dst0_send_ready, dst1_send_ready,
    output src0_rd_req, src1_rd_req,
    output enc_recv_ready, enc_in_data, enc_end_of_stream, enc_send_ready,
    output dst0_wr_req, dst1_wr_req, dst_data,
    output owner, busy, drain_timeout, stream_cnt0, stream_cnt1
  );

  modport master (
    output src0_recv_ready, src0_data, src0_eos,
    output src1_recv_ready, src1_data, src1_eos,
    output enc_rd_req, enc_out_data, enc_wr_req,
    output dst0_send_ready, dst1_send_ready,
    input  src0_rd_req, src1_rd_req,
    input  enc_recv_ready, enc_in_data, enc_end_of_stream, enc_send_ready,
    input  dst0_wr_req, dst1_wr_req, dst_data,
    input  owner, busy, drain_timeout, stream_cnt0, stream_cnt1
  );
endinterface

// File: rtl/rle_stream_arb.sv
// Round-robin stream arbiter sharing one RLE encoder between two sources and two sinks.
// A grant covers a whole stream plus the drain of its final run record.
module rle_stream_arb #(
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  rle_stream_arb_if.slave   bus
);

  localparam int unsigned    DW         = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             timeout_q, timeout_d;

  logic             sel_ready;
  logic [7:0]       sel_data;
  logic             sel_eos;
  logic             sel_dst_ready;
  logic             byte_acc;
  logic             rec_acc;
  logic             active;
  logic             in_grant;
  logic             routed;

  always_comb begin
    sel_ready     = owner_q ? bus.src1_recv_ready : bus.src0_recv_ready;
    sel_data      = owner_q ? bus.src1_data       : bus.src0_data;
    sel_eos       = owner_q ? bus.src1_eos        : bus.src0_eos;
    sel_dst_ready = owner_q ? bus.dst1_send_ready : bus.dst0_send_ready;
    byte_acc      = (state_q == GRANT) && bus.enc_rd_req && sel_ready;
    rec_acc       = (state_q != IDLE) && bus.enc_wr_req && sel_dst_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      drain_cnt_q  <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      drain_cnt_q  <= drain_cnt_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    drain_cnt_d  = drain_cnt_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    timeout_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.src0_recv_ready || bus.src1_recv_ready) begin
          // Tie goes to whichever source did not own the previous stream.
          owner_d = (bus.src0_recv_ready && bus.src1_recv_ready) ? ~last_owner_q
                                                                 : bus.src1_recv_ready;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (byte_acc && sel_eos) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (rec_acc) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          if (owner_q) cnt1_d = cnt1_q + 1'b1;
          else         cnt0_d = cnt0_q + 1'b1;
        end else if (sel_dst_ready) begin
          // Only cycles where the sink could have taken a record count toward release.
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            timeout_d    = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active   = !rst;
    in_grant = active && (state_q == GRANT);
    routed   = active && (state_q != IDLE);

    bus.enc_recv_ready    = in_grant && sel_ready;
    bus.enc_in_data       = sel_data;
    bus.enc_end_of_stream = in_grant && sel_eos;
    bus.src0_rd_req       = in_grant && !owner_q && bus.enc_rd_req && bus.src0_recv_ready;
    bus.src1_rd_req       = in_grant &&  owner_q && bus.enc_rd_req && bus.src1_recv_ready;

    bus.enc_send_ready    = routed && sel_dst_ready;
    bus.dst0_wr_req       = routed && !owner_q && bus.enc_wr_req && bus.dst0_send_ready;
    bus.dst1_wr_req       = routed &&  owner_q && bus.enc_wr_req && bus.dst1_send_ready;
    bus.dst_data          = bus.enc_out_data;

    bus.owner             = owner_q;
    bus.busy              = (state_q != IDLE);
    bus.drain_timeout     = timeout_q;
    bus.stream_cnt0       = cnt0_q;
    bus.stream_cnt1       = cnt1_q;
  end

endmodule

// File: tb/tb_rle_stream_arb.sv
// Directed bench for rle_stream_arb: a per-cycle vector table plus hand-written
// back-pressure, timeout and mid-stream reset sequences.
module tb_rle_stream_arb;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned TO    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rle_stream_arb_if #(.CNT_W(CNT_W)) bus();

  rle_stream_arb #(.DRAIN_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        s0r; logic [7:0] s0d; logic s0e;
    logic        s1r; logic [7:0] s1d; logic s1e;
    logic        erd; logic ewr; logic [23:0] eout;
    logic        d0r; logic d1r;
    logic        x_s0rd; logic x_s1rd; logic x_err; logic [7:0] x_edata; logic x_eeos;
    logic        x_esr;  logic x_d0w;  logic x_d1w; logic x_own; logic x_busy;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                 = v.rst;
    bus.src0_recv_ready = v.s0r; bus.src0_data = v.s0d; bus.src0_eos = v.s0e;
    bus.src1_recv_ready = v.s1r; bus.src1_data = v.s1d; bus.src1_eos = v.s1e;
    bus.enc_rd_req      = v.erd; bus.enc_wr_req = v.ewr; bus.enc_out_data = v.eout;
    bus.dst0_send_ready = v.d0r; bus.dst1_send_ready = v.d1r;
  endtask

  task automatic quiet();
    bus.src0_recv_ready = 1'b0; bus.src0_data = 8'h00; bus.src0_eos = 1'b0;
    bus.src1_recv_ready = 1'b0; bus.src1_data = 8'h00; bus.src1_eos = 1'b0;
    bus.enc_rd_req = 1'b0; bus.enc_wr_req = 1'b0; bus.enc_out_data = 24'h0;
    bus.dst0_send_ready = 1'b1; bus.dst1_send_ready = 1'b1;
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, ".src0_rd_req"},    bus.src0_rd_req,    1'b0);
    chk({tag, ".src1_rd_req"},    bus.src1_rd_req,    1'b0);
    chk({tag, ".enc_recv_ready"}, bus.enc_recv_ready, 1'b0);
    chk({tag, ".enc_send_ready"}, bus.enc_send_ready, 1'b0);
    chk({tag, ".dst0_wr_req"},    bus.dst0_wr_req,    1'b0);
    chk({tag, ".dst1_wr_req"},    bus.dst1_wr_req,    1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    // rst, s0r,s0d,s0e, s1r,s1d,s1e, erd,ewr,eout, d0r,d1r,
    // x_s0rd,x_s1rd,x_err,x_edata,x_eeos,x_esr,x_d0w,x_d1w, x_own,x_busy
    vecs[0]  = '{1, 1,8'h00,0, 1,8'h00,0, 1,1,24'h000000, 1,1, 0,0,0,8'h00,0,0,0,0, 0,0};
    vecs[1]  = '{0, 1,8'hFF,0, 1,8'h55,0, 1,0,24'h000000, 1,1, 0,0,0,8'h00,0,0,0,0, 0,0};
    vecs[2]  = '{0, 1,8'hFF,0, 1,8'h55,0, 1,0,24'h000000, 1,1, 1,0,1,8'hFF,0,1,0,0, 0,1};
    vecs[3]  = '{0, 1,8'hFF,1, 1,8'h55,0, 1,1,24'hFF0002, 1,1, 1,0,1,8'hFF,1,1,1,0, 0,1};
    vecs[4]  = '{0, 1,8'hFF,0, 1,8'h55,0, 1,0,24'h000000, 1,1, 0,0,0,8'h00,0,1,0,0, 0,1};
    vecs[5]  = '{0, 1,8'hFF,0, 1,8'h55,0, 1,1,24'hFF0001, 0,1, 0,0,0,8'h00,0,0,0,0, 0,1};
    vecs[6]  = '{0, 1,8'hFF,0, 1,8'h55,0, 1,1,24'hFF0001, 1,1, 0,0,0,8'h00,0,1,1,0, 0,1};
    vecs[7]  = '{0, 1,8'hFF,0, 1,8'h55,0, 1,1,24'h000000, 1,1, 0,0,0,8'h00,0,0,0,0, 0,0};
    vecs[8]  = '{0, 1,8'h77,0, 1,8'h55,0, 1,0,24'h000000, 1,1, 0,1,1,8'h55,0,1,0,0, 1,1};
    vecs[9]  = '{0, 1,8'h77,0, 0,8'hAA,0, 1,1,24'h550001, 1,0, 0,0,0,8'h00,0,0,0,0, 1,1};
    vecs[10] = '{0, 1,8'h77,0, 1,8'hAA,0, 0,1,24'h550001, 1,1, 0,0,1,8'hAA,0,1,0,1, 1,1};
    vecs[11] = '{0, 1,8'h77,0, 1,8'h55,1, 1,0,24'h000000, 1,1, 0,1,1,8'h55,1,1,0,0, 1,1};
    vecs[12] = '{0, 1,8'h77,0, 1,8'h55,0, 1,1,24'hAA0001, 1,1, 0,0,0,8'h00,0,1,0,1, 1,1};
    vecs[13] = '{0, 0,8'h77,0, 1,8'h12,0, 1,1,24'h000000, 1,1, 0,0,0,8'h00,0,0,0,0, 1,0};
    vecs[14] = '{0, 0,8'h77,0, 1,8'h12,1, 1,0,24'h000000, 1,1, 0,1,1,8'h12,1,1,0,0, 1,1};
    vecs[15] = '{0, 0,8'h00,0, 0,8'h00,0, 0,1,24'h120001, 1,1, 0,0,0,8'h00,0,1,0,1, 1,1};
    vecs[16] = '{0, 0,8'h00,0, 0,8'h00,0, 1,1,24'h000000, 1,1, 0,0,0,8'h00,0,0,0,0, 1,0};

    quiet();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d.src0_rd_req", i),       bus.src0_rd_req,       vecs[i].x_s0rd);
      chk($sformatf("v%0d.src1_rd_req", i),       bus.src1_rd_req,       vecs[i].x_s1rd);
      chk($sformatf("v%0d.enc_recv_ready", i),    bus.enc_recv_ready,    vecs[i].x_err);
      if (vecs[i].x_err)
        chk($sformatf("v%0d.enc_in_data", i),     bus.enc_in_data,       vecs[i].x_edata);
      chk($sformatf("v%0d.enc_end_of_stream", i), bus.enc_end_of_stream, vecs[i].x_eeos);
      chk($sformatf("v%0d.enc_send_ready", i),    bus.enc_send_ready,    vecs[i].x_esr);
      chk($sformatf("v%0d.dst0_wr_req", i),       bus.dst0_wr_req,       vecs[i].x_d0w);
      chk($sformatf("v%0d.dst1_wr_req", i),       bus.dst1_wr_req,       vecs[i].x_d1w);
      chk($sformatf("v%0d.dst_data", i),          bus.dst_data,          vecs[i].eout);
      chk($sformatf("v%0d.owner", i),             bus.owner,             vecs[i].x_own);
      chk($sformatf("v%0d.busy", i),              bus.busy,              vecs[i].x_busy);
    end
    chk("table.stream_cnt0",   bus.stream_cnt0,   32'd1);
    chk("table.stream_cnt1",   bus.stream_cnt1,   32'd2);
    chk("table.drain_timeout", bus.drain_timeout, 1'b0);

    // Back-pressure on the final record: src0 granted alone, eos, then dst0 stalls.
    @(negedge clk); quiet(); bus.src0_recv_ready = 1'b1;
    @(negedge clk); bus.src0_data = 8'h00; bus.src0_eos = 1'b1; bus.enc_rd_req = 1'b1;
    #1; chk("bp.eos_pop", bus.src0_rd_req, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.src0_eos = 1'b0; bus.enc_rd_req = 1'b1;
      bus.enc_wr_req = 1'b1; bus.enc_out_data = 24'h000006; bus.dst0_send_ready = 1'b0;
      #1;
      chk($sformatf("bp%0d.enc_send_ready", i), bus.enc_send_ready, 1'b0);
      chk($sformatf("bp%0d.dst0_wr_req", i),    bus.dst0_wr_req,    1'b0);
      chk($sformatf("bp%0d.src0_rd_req", i),    bus.src0_rd_req,    1'b0);
      chk($sformatf("bp%0d.drain_timeout", i),  bus.drain_timeout,  1'b0);
      chk($sformatf("bp%0d.busy", i),           bus.busy,           1'b1);
    end
    @(negedge clk); bus.dst0_send_ready = 1'b1;
    #1;
    chk("bp.release.dst0_wr_req", bus.dst0_wr_req, 1'b1);
    chk("bp.release.dst1_wr_req", bus.dst1_wr_req, 1'b0);
    chk("bp.release.dst_data",    bus.dst_data,    32'h000006);
    @(negedge clk); quiet();
    #1;
    chk("bp.after.stream_cnt0", bus.stream_cnt0, 32'd2);
    chk("bp.after.busy",        bus.busy,        1'b0);

    // Timeout: 5 stalled drain cycles then TO counting cycles with no record.
    @(negedge clk); quiet(); bus.src0_recv_ready = 1'b1;
    @(negedge clk); bus.src0_data = 8'h33; bus.src0_eos = 1'b1; bus.enc_rd_req = 1'b1;
    #1; chk("to.eos_pop", bus.src0_rd_req, 1'b1);
    n = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      bus.src0_eos = 1'b0; bus.src1_recv_ready = 1'b1; bus.enc_rd_req = 1'b1;
      bus.dst0_send_ready = (n < 5) ? 1'b0 : 1'b1;
      #1;
      if (bus.drain_timeout) seen = 1'b1;
      else begin
        if (bus.src0_rd_req || bus.src1_rd_req) begin
          errors++;
          $display("FAIL to.rd_req_in_drain: got 1 expected 0 at cycle %0d", n);
        end
        n++;
      end
    end
    chk("to.seen",        {31'd0, seen}, 32'd1);
    chk("to.latency",     n,               TO + 5);
    chk("to.busy",        bus.busy,        1'b0);
    chk("to.stream_cnt0", bus.stream_cnt0, 32'd2);
    @(negedge clk);
    #1;
    chk("to.pulse_width", bus.drain_timeout, 1'b0);
    chk("to.next_owner",  bus.owner,         1'b1);
    chk("to.next_busy",   bus.busy,          1'b1);

    // Reset mid-stream: src1 owns, 4 of 8 bytes popped, then rst.
    for (int i = 0; i < 4; i++) begin
      bus.src1_data = 8'(i + 1); bus.src1_eos = 1'b0;
      #1;
      chk($sformatf("rs%0d.src1_rd_req", i), bus.src1_rd_req, 1'b1);
      chk($sformatf("rs%0d.src0_rd_req", i), bus.src0_rd_req, 1'b0);
      @(negedge clk);
    end
    rst = 1'b1; bus.enc_wr_req = 1'b1; bus.dst1_send_ready = 1'b1;
    #1;
    chk_all_low("rst_cycle");
    @(negedge clk);
    rst = 1'b0; bus.src0_recv_ready = 1'b1; bus.src1_recv_ready = 1'b1;
    #1;
    chk_all_low("post_rst");
    chk("post_rst.busy",          bus.busy,          1'b0);
    chk("post_rst.owner",         bus.owner,         1'b0);
    chk("post_rst.stream_cnt0",   bus.stream_cnt0,   32'd0);
    chk("post_rst.stream_cnt1",   bus.stream_cnt1,   32'd0);
    chk("post_rst.drain_timeout", bus.drain_timeout, 1'b0);
    @(negedge clk);
    #1;
    chk("post_rst.first_owner", bus.owner, 1'b0);
    chk("post_rst.first_busy",  bus.busy,  1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
